// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry helpers
// for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w,
                               input int num_sets,
                               input int line_words);
    return addr_w - index_w(num_sets) - offset_w(line_words);
  endfunction

endpackage

// File: rtl/dcache_word_fmt.sv
// dcache_word_fmt: load extract/extend and store
// byte-merge for one 32-bit word.
module dcache_word_fmt
  import dcache_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [3:0]  be;
  logic [31:0] wd;

  assign bsel = word[{byte_off, 3'b000} +: 8];
  assign hsel = byte_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    rdata = word;
    unique case (1'b1)
      (funct3 == F3_B):  rdata = {{24{bsel[7]}}, bsel};
      (funct3 == F3_H):  rdata = {{16{hsel[15]}}, hsel};
      (funct3 == F3_BU): rdata = {24'd0, bsel};
      (funct3 == F3_HU): rdata = {16'd0, hsel};
      default:           rdata = word;
    endcase
  end

  always_comb begin
    be = 4'b1111;
    wd = wdata;
    unique case (1'b1)
      (funct3[1:0] == 2'b00): begin
        be = 4'b0001 << byte_off;
        wd = {4{wdata[7:0]}};
      end
      (funct3[1:0] == 2'b01): begin
        be = byte_off[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata;
      end
    endcase
  end

  always_comb begin
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back, write-allocate
// data cache with a req/ack line interface to memory.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cpu_rd_en,
  input  logic                             cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  input  logic [2:0]                       cpu_funct3,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             cpu_stall,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_rdata,
  input  logic                             mem_ack
);

  localparam int OW = offset_w(LINE_WORDS);
  localparam int IW = index_w(NUM_SETS);
  localparam int TW = tag_w(ADDR_WIDTH, NUM_SETS, LINE_WORDS);
  localparam int SW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;

  state_t state_q, state_d;

  logic [TW-1:0]       tag_q [NUM_SETS];
  line_t               data_q [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  logic [IW-1:0]         idx;
  logic [TW-1:0]         tag;
  logic [SW-1:0]         wsel;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] st_word;
  logic                  access;
  logic                  hit;
  logic                  fill;
  logic                  st_hit;

  assign idx = cpu_addr[OW +: IW];
  assign tag = cpu_addr[OW+IW +: TW];

  if (LINE_WORDS > 1) begin : g_wsel
    assign wsel = cpu_addr[2 +: SW];
  end else begin : g_wsel_one
    assign wsel = '0;
  end

  assign access   = cpu_rd_en | cpu_wr_en;
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign cur_word = data_q[idx][wsel];
  assign fill     = (state_q == REFILL) && mem_ack;
  assign st_hit   = (state_q == IDLE) && cpu_wr_en && hit;

  dcache_word_fmt u_fmt (
    .funct3   (cpu_funct3),
    .byte_off (cpu_addr[1:0]),
    .word     (cur_word),
    .wdata    (cpu_wdata),
    .rdata    (cpu_rdata),
    .merged   (st_word)
  );

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = data_q[idx];
    cpu_stall = 1'b1;
    unique case (state_q)
      IDLE: begin
        cpu_stall = access && !hit;
        if (access && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_q[idx], idx, {OW{1'b0}}};
        if (mem_ack) state_d = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, {OW{1'b0}}};
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (st_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // tag/data carry no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if (st_hit) begin
      data_q[idx][wsel] <= st_word;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed + random checks of dcache_ctrl
// against a transaction-level cache/memory model.
module tb_dcache_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 64;
  localparam int LWD = 4;
  localparam int LBW = LWD * DW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cpu_rd_en = 1'b0;
  logic           cpu_wr_en = 1'b0;
  logic [AW-1:0]  cpu_addr = '0;
  logic [DW-1:0]  cpu_wdata = '0;
  logic [2:0]     cpu_funct3 = 3'b010;
  logic [DW-1:0]  cpu_rdata;
  logic           cpu_stall;
  logic           mem_req;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [LBW-1:0] mem_wdata;
  logic [LBW-1:0] mem_rdata = '0;
  logic           mem_ack = 1'b0;

  always #5 clk = ~clk;

  dcache_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_SETS   (NS),
    .LINE_WORDS (LWD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_rd_en  (cpu_rd_en),
    .cpu_wr_en  (cpu_wr_en),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_funct3 (cpu_funct3),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  int n_chk = 0;
  int n_fail = 0;

  bit              mvalid [NS];
  bit              mdirty [NS];
  int unsigned     mtag [NS];
  logic [LBW-1:0]  mline [NS];
  logic [LBW-1:0]  backing [int unsigned];

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [LBW-1:0] get_line(input int unsigned la);
    if (!backing.exists(la))
      backing[la] = {$urandom, $urandom, $urandom, $urandom};
    return backing[la];
  endfunction

  function automatic logic [31:0] load_ref(input logic [31:0] w,
                                           input logic [2:0] f3,
                                           input int off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7] ? (b | 32'hFFFFFF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_ref(input logic [31:0] w,
                                            input logic [31:0] wd,
                                            input logic [2:0] f3,
                                            input int off);
    logic [31:0] r;
    r = w;
    case (f3[1:0])
      2'b00:   r[8*off +: 8] = wd[7:0];
      2'b01:   r[16*(off/2) +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // One CPU access, starting and ending at a negedge.
  task automatic do_access(input bit rd, input bit wr,
                           input logic [31:0] addr,
                           input logic [31:0] wd,
                           input logic [2:0] f3,
                           input int ww, input int wrw,
                           output int stalls,
                           output logic [31:0] rdat,
                           output logic [31:0] wb_w1,
                           output logic [31:0] wb_a);
    int unsigned idx, tg, la, va;
    int          wsel, off;
    bit          hit, vdirty;
    logic [LBW-1:0] rl;
    logic [31:0] w;
    idx = (addr >> 4) % NS;
    tg = addr >> 10;
    la = addr & ~32'hF;
    wsel = int'((addr >> 2) & 3);
    off = int'(addr & 3);
    hit = mvalid[idx] && (mtag[idx] == tg);
    vdirty = !hit && mvalid[idx] && mdirty[idx];
    stalls = 0;
    wb_w1 = '0;
    wb_a = '0;
    cpu_rd_en = rd;
    cpu_wr_en = wr;
    cpu_addr = addr;
    cpu_wdata = wd;
    cpu_funct3 = f3;
    mem_ack = 1'b0;
    if (!hit) begin
      #1;
      chk("miss_stall", 128'(cpu_stall), 128'(1'b1));
      chk("miss_idle_req", 128'(mem_req), 128'(1'b0));
      if (cpu_stall) stalls++;
      @(negedge clk);
      if (vdirty) begin
        va = (mtag[idx] << 10) | (idx << 4);
        for (int k = 0; k <= ww; k++) begin
          #1;
          chk("wb_stall", 128'(cpu_stall), 128'(1'b1));
          chk("wb_req", 128'({mem_req, mem_we}), 128'(2'b11));
          chk("wb_addr", 128'(mem_addr), 128'(va));
          chk("wb_data", 128'(mem_wdata), 128'(mline[idx]));
          if (cpu_stall) stalls++;
          if (k == 0) begin
            wb_w1 = mem_wdata[63:32];
            wb_a = mem_addr;
          end
          mem_ack = (k == ww);
          @(negedge clk);
          mem_ack = 1'b0;
        end
        backing[va] = mline[idx];
      end
      rl = get_line(la);
      for (int k = 0; k <= wrw; k++) begin
        #1;
        chk("rf_stall", 128'(cpu_stall), 128'(1'b1));
        chk("rf_req", 128'({mem_req, mem_we}), 128'(2'b10));
        chk("rf_addr", 128'(mem_addr), 128'(la));
        if (cpu_stall) stalls++;
        mem_rdata = rl;
        mem_ack = (k == wrw);
        @(negedge clk);
        mem_ack = 1'b0;
      end
      mvalid[idx] = 1'b1;
      mdirty[idx] = 1'b0;
      mtag[idx] = tg;
      mline[idx] = rl;
    end
    #1;
    chk("done_stall", 128'(cpu_stall), 128'(1'b0));
    chk("done_req", 128'(mem_req), 128'(1'b0));
    w = mline[idx][32*wsel +: 32];
    rdat = cpu_rdata;
    if (rd && !wr) chk("load_data", 128'(cpu_rdata), 128'(load_ref(w, f3, off)));
    mem_ack = ($urandom_range(0, 3) == 0);
    if (wr) begin
      mline[idx][32*wsel +: 32] = store_ref(w, wd, f3, off);
      mdirty[idx] = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
  endtask

  initial begin
    int st;
    logic [31:0] rd, w1, wa;
    logic [2:0] f3s [5];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_stall", 128'(cpu_stall), 128'(1'b0));
    chk("rst_req", 128'(mem_req), 128'(1'b0));
    chk("rst_we", 128'(mem_we), 128'(1'b0));
    @(negedge clk);

    backing[32'h100] = {32'h33333333, 32'h22222222,
                        32'hDEADBEEF, 32'h11111111};
    do_access(1, 0, 32'h100, 0, 3'b010, 0, 0, st, rd, w1, wa);
    chk("cold_stall_cnt", 128'(st), 128'(2));
    chk("cold_lw0", 128'(rd), 128'(32'h11111111));
    do_access(1, 0, 32'h104, 0, 3'b010, 0, 0, st, rd, w1, wa);
    chk("lw104", 128'(rd), 128'(32'hDEADBEEF));
    chk("lw104_stall", 128'(st), 128'(0));
    do_access(1, 0, 32'h107, 0, 3'b000, 0, 0, st, rd, w1, wa);
    chk("lb107", 128'(rd), 128'(32'hFFFFFFDE));
    do_access(1, 0, 32'h107, 0, 3'b100, 0, 0, st, rd, w1, wa);
    chk("lbu107", 128'(rd), 128'(32'h000000DE));
    do_access(1, 0, 32'h106, 0, 3'b001, 0, 0, st, rd, w1, wa);
    chk("lh106", 128'(rd), 128'(32'hFFFFDEAD));
    do_access(1, 0, 32'h104, 0, 3'b101, 0, 0, st, rd, w1, wa);
    chk("lhu104", 128'(rd), 128'(32'h0000BEEF));
    do_access(0, 1, 32'h105, 32'h11, 3'b000, 0, 0, st, rd, w1, wa);
    do_access(1, 0, 32'h104, 0, 3'b010, 0, 0, st, rd, w1, wa);
    chk("sb_merge", 128'(rd), 128'(32'hDEAD11EF));

    do_access(1, 0, 32'h500, 0, 3'b010, 3, 2, st, rd, w1, wa);
    chk("dirty_stall_cnt", 128'(st), 128'(8));
    chk("wb_word1", 128'(w1), 128'(32'hDEAD11EF));
    chk("wb_addr_lit", 128'(wa), 128'(32'h100));

    do_access(1, 1, 32'h508, 32'hCAFEF00D, 3'b010, 0, 0, st, rd, w1, wa);
    do_access(1, 0, 32'h508, 0, 3'b010, 0, 0, st, rd, w1, wa);
    chk("rdwr_store", 128'(rd), 128'(32'hCAFEF00D));
    do_access(1, 0, 32'h100, 0, 3'b010, 0, 0, st, rd, w1, wa);
    chk("rdwr_dirty_cnt", 128'(st), 128'(3));

    cpu_rd_en = 1'b1;
    cpu_addr = 32'h2A0;
    cpu_funct3 = 3'b010;
    #1;
    chk("rr_idle_stall", 128'(cpu_stall), 128'(1'b1));
    @(negedge clk);
    #1;
    chk("rr_refill_req", 128'({mem_req, mem_we}), 128'(2'b10));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cpu_rd_en = 1'b0;
    #1;
    chk("rr_req_drop", 128'(mem_req), 128'(1'b0));
    chk("rr_stall_drop", 128'(cpu_stall), 128'(1'b0));
    for (int i = 0; i < NS; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    @(negedge clk);
    do_access(1, 0, 32'h2A0, 0, 3'b010, 0, 1, st, rd, w1, wa);
    chk("rr_reaccess_cnt", 128'(st), 128'(3));

    for (int n = 0; n < 400; n++) begin
      int op, b;
      logic [31:0] a;
      logic [2:0] f3;
      op = int'($urandom_range(0, 2));
      f3 = (op == 0) ? f3s[$urandom_range(0, 4)] : f3s[$urandom_range(0, 2)];
      b = int'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) b = b & 2;
      if (f3[1:0] == 2'b10) b = 0;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4)
        | ($urandom_range(0, 3) << 2) | b;
      do_access(op != 1, op != 0, a, $urandom, f3,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                st, rd, w1, wa);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Parametrised write-back, write-allocate, direct-mapped data cache with its own miss-handling state machine and a req/ack line interface to backing memory. Next generation of the memory-stage cache path: it replaces the fixed single-cycle fetch/write-back wiring with a variable-latency memory handshake and drives a pipeline stall while a miss is serviced. It sits between the MEM stage (address from the ALU result, store data, funct3) and the block-wide data memory.

## Interface
- DATA_WIDTH, 32, CPU word width; must be 32.
- ADDR_WIDTH, 32, byte-address width.
- NUM_SETS, 64, number of lines; power of two, ≥2.
- LINE_WORDS, 4, words per line; power of two, ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cpu_rd_en  in  1  load request.
- cpu_wr_en  in  1  store request.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  store data, right-aligned.
- cpu_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- cpu_rdata  out  DATA_WIDTH  extended load data.
- cpu_stall  out  1  hold MEM stage; request inputs must stay stable while high.
- mem_req  out  1  memory transaction valid.
- mem_we  out  1  1 = line write-back, 0 = line refill.
- mem_addr  out  ADDR_WIDTH  line-aligned address; offset bits zero.
- mem_wdata  out  LINE_WORDS*DATA_WIDTH  victim line, word 0 in LSBs.
- mem_rdata  in  LINE_WORDS*DATA_WIDTH  refill line, word 0 in LSBs.
- mem_ack  in  1  transaction complete; single-cycle pulse, may arrive in the first req cycle.

## Operation
- Address split: OFFSET = log2(LINE_WORDS*4) bits, INDEX = log2(NUM_SETS), TAG = remainder. Word select = addr[OFFSET-1:2]; byte lane = addr[1:0].
- Hit = valid[index] & tag match. Access = cpu_rd_en | cpu_wr_en; if both are high, the store wins.
- Load hit: cpu_rdata combinational; B/H sign-extended, BU/HU zero-extended, W passes through. Halfword uses addr[1]. Misaligned accesses are unsupported and return unspecified data with no state corruption beyond the addressed word.
- Store hit: byte-enable merge (B one lane, H two lanes, W all) at the edge; dirty[index] set.
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE: access & miss → WRITEBACK if valid&dirty at index, else REFILL. mem_req=0.
  - WRITEBACK: mem_req=1, mem_we=1, mem_addr={stored tag, index, 0}, mem_wdata=stored line. On mem_ack → REFILL.
  - REFILL: mem_req=1, mem_we=0, mem_addr={cpu tag, index, 0}. On mem_ack: line←mem_rdata, tag written, valid=1, dirty=0 → IDLE.
- After returning to IDLE the held access re-evaluates as a hit and completes normally (store then sets dirty).
- cpu_stall = (access & ~hit in IDLE) | (state ≠ IDLE). Combinational.
- mem_req, mem_we, mem_addr, mem_wdata are decoded from state and stable for the whole transaction. mem_ack in IDLE is ignored.

## Timing
- Reset (rst_n low at an edge): all valid and dirty bits cleared, state IDLE. Next cycle: mem_req=0, mem_we=0, cpu_stall=0 absent an access. Tag/data arrays are not reset. cpu_rdata is unspecified while there is no load hit.
- Reset mid-WRITEBACK/REFILL: the transaction is abandoned and mem_req drops in the following cycle. Backing memory must tolerate the abandoned request.
- Hit: 0-cycle load latency; a store commits at the end of the cycle; no stall.
- Clean miss, ack after W wait cycles (W=0 means ack in the first req cycle): cpu_stall high for W+2 cycles, and the access completes in cycle W+2.
- Dirty miss: stall = Ww + Wr + 3 cycles.
- Simultaneous store hit and reset: reset wins; no array write is required to be observable.

## Structure
- Package dcache_pkg: state enum (IDLE, WRITEBACK, REFILL), funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), and localparam functions for OFFSET/INDEX/TAG widths.
- Sub-module dcache_word_fmt (combinational): load extract/extend and store byte-merge from funct3 and addr[1:0]. Reused by the instruction/uncached path.
- Arrays: tag, valid, dirty, and data as flat registers indexed by set. No SRAM macro.

## Test plan
- Reset, then LW 0x100 (cold): stall 2 cycles with 0-wait ack. mem_addr=0x100, mem_we=0. Refill word1=0xDEADBEEF, LW 0x104 → 0xDEADBEEF, no stall.
- After that refill: LB 0x107 → 0xFFFFFFDE; LBU 0x107 → 0x000000DE; LH 0x106 → 0xFFFFDEAD; LHU 0x104 → 0x0000BEEF.
- SB 0x105 data 0x11 on the hit line. LW 0x104 → 0xDEAD11EF. The line is now dirty.
- LW 0x100+NUM_SETS*16 (conflict, dirty): WRITEBACK issues mem_addr=0x100, mem_we=1, with word1 of mem_wdata=0xDEAD11EF. Ack after 3 waits, then REFILL with ack after 2 waits. Stall = 3+2+3 = 8 cycles.
- cpu_rd_en and cpu_wr_en both high on a hit: the store is performed and dirty is set. A stray mem_ack in IDLE causes no state change.
- Drop rst_n during REFILL: mem_req low in the next cycle. A re-access of the same address misses (valid cleared) and refills cleanly.
